// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
package arb_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so index vectors always have a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
interface rr_reg_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OW     = clog2(N_REQ)
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       q;
  logic [DATA_W-1:0]       qbar;
  logic [OW-1:0]           owner;
  logic                    busy;

  modport master (
    output req, lock, wdata,
    input  gnt, ack, q, qbar, owner, busy
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, ack, q, qbar, owner, busy
  );

endinterface

// File: rtl/rr_reg_arbiter_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx
);

  int unsigned c;

  // Scan ptr, ptr+1, ... modulo N_REQ and keep the first hit.
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    c      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      c = 32'(ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!valid && req[c]) begin
        valid     = 1'b1;
        onehot[c] = 1'b1;
        idx       = IW'(c);
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter owning the shared q/qbar register bank.
module rr_reg_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_LOCK = 4
) (
  input logic             clk,
  input logic             rst,
  rr_reg_arbiter_if.slave bus
);

  localparam int unsigned OW = clog2(N_REQ);
  localparam int unsigned LW = clog2(MAX_LOCK + 1);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [OW-1:0]     owner_nxt;
  logic [LW-1:0]     cnt_q, cnt_d;

  logic              pick_valid;
  logic [N_REQ-1:0]  pick_onehot;
  logic [OW-1:0]     pick_idx;

  logic              own_req;
  logic              own_lock;
  logic [DATA_W-1:0] own_wdata;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (OW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Select the current owner's request, lock and write data.
  always_comb begin
    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        own_req   = bus.req[i];
        own_lock  = bus.lock[i];
        own_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign owner_nxt = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Next-state, grant, commit and priority-rotation decisions.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    q_d     = q_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          cnt_d   = LW'(1);
        end
      end
      ST_GRANT: begin
        if (own_req) begin
          q_d     = own_wdata;
          ack_d   = gnt_q;
          state_d = ST_ACK;
        end else begin
          gnt_d   = '0;
          ptr_d   = owner_nxt;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (own_lock && own_req && (cnt_q < LW'(MAX_LOCK))) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_GRANT;
        end else begin
          gnt_d   = '0;
          ptr_d   = owner_nxt;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.q     = q_q;
  assign bus.qbar  = ~q_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q != ST_IDLE);

endmodule
